// File: rtl/conv_row_adr_sequencer.sv
// Row-tile address sequencer: walks ky / pixel chunk / input channel, one valid_adr beat per cycle,
// then drains the downstream controller latency before pulsing done. Optional CONV_ROW_SEQ_PERF_CNT_EN adds stall_cnt.
module conv_row_adr_sequencer #(
  parameter int pixels_in_row         = 32,
  parameter int pixels_in_row_in_2pow = 5,
  parameter int ctrl_latency          = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  k_init,
  input  logic [3:0]  nif_in_2pow_init,
  input  logic [3:0]  ix_in_2pow_init,
  input  logic [15:0] iy_start_in,
  input  logic [15:0] row_base_in_3s_in,
  input  logic [3:0]  slab_num_in,
  input  logic        hold,
  output logic        valid_adr,
  output logic [15:0] iy_start,
  output logic [15:0] ky,
  output logic [15:0] row_base_in_3s,
  output logic [15:0] row_start_idx,
  output logic [15:0] if_start,
  output logic [3:0]  slab_num,
  output logic [15:0] row_slab_start_idx,
  output logic        busy,
  output logic        done
`ifdef CONV_ROW_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_reg;
  logic [15:0] nif_reg;
  logic [15:0] chunks_reg;
  logic [15:0] k_reg;
  logic [15:0] chunk_idx_reg;
  logic [7:0]  drain_cnt_reg;

  logic [15:0] nif_next;
  logic [15:0] chunks_next;
  logic [3:0]  ix_shift;
  logic        last_if;
  logic        last_chunk;
  logic        last_beat;

  always_comb begin
    ix_shift    = ix_in_2pow_init - 4'(pixels_in_row_in_2pow);
    nif_next    = 16'd1 << nif_in_2pow_init;
    chunks_next = (ix_in_2pow_init <= 4'(pixels_in_row_in_2pow)) ? 16'd1 : (16'd1 << ix_shift);
    last_if     = (if_start == nif_reg);
    last_chunk  = (chunk_idx_reg == chunks_reg - 16'd1);
    last_beat   = last_if && last_chunk && (ky == k_reg - 16'd1);
  end

  assign row_slab_start_idx = row_start_idx;

  // Counters always show the beat being (or about to be) presented; a presented beat is consumed
  // at the edge, and hold only gates whether the next one is marked valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      valid_adr      <= 1'b0;
      iy_start       <= '0;
      ky             <= '0;
      row_base_in_3s <= '0;
      row_start_idx  <= '0;
      if_start       <= 16'd1;
      slab_num       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      nif_reg        <= '0;
      chunks_reg     <= '0;
      k_reg          <= '0;
      chunk_idx_reg  <= '0;
      drain_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            iy_start       <= iy_start_in;
            row_base_in_3s <= row_base_in_3s_in;
            slab_num       <= slab_num_in;
            nif_reg        <= nif_next;
            chunks_reg     <= chunks_next;
            k_reg          <= {12'd0, k_init};
            ky             <= '0;
            row_start_idx  <= '0;
            if_start       <= 16'd1;
            chunk_idx_reg  <= '0;
            drain_cnt_reg  <= '0;
            busy           <= 1'b1;
            if (k_init == 4'd0) begin
              state_reg <= DRAIN;
              valid_adr <= 1'b0;
            end else begin
              state_reg <= RUN;
              valid_adr <= ~hold;
            end
          end
        end
        RUN: begin
          if (valid_adr && last_beat) begin
            valid_adr     <= 1'b0;
            drain_cnt_reg <= '0;
            state_reg     <= DRAIN;
          end else begin
            valid_adr <= ~hold;
            if (valid_adr) begin
              if (last_if) begin
                if_start <= 16'd1;
                if (last_chunk) begin
                  chunk_idx_reg <= '0;
                  row_start_idx <= '0;
                  ky            <= ky + 16'd1;
                end else begin
                  chunk_idx_reg <= chunk_idx_reg + 16'd1;
                  row_start_idx <= row_start_idx + 16'(pixels_in_row);
                end
              end else begin
                if_start <= if_start + 16'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == 8'(ctrl_latency - 1)) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 8'd1;
          end
        end
        default: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef CONV_ROW_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state_reg == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state_reg == RUN && hold && stall_cnt != 32'hffff_ffff) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
